duty_ramp: RTL and testbench

//  Soft-start / slew limiter that sits directly upstream of the PWM generator and drives its 10-bit duty input.

---
 rtl/duty_ramp.sv | 120 ++++++++++++
 tb/tb_duty_ramp.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// Slew-limited duty command for the PWM stage: moves duty toward an accepted target by at most
// STEP per PWM period, updating only at period boundaries. Define DUTY_CLAMP_EN to clamp targets to MAX_DUTY.
module duty_ramp #(
  parameter int unsigned STEP     = 8,
  parameter int unsigned MAX_DUTY = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tgt_duty,
  input  logic       tgt_vld,
  output logic       tgt_rdy,
  input  logic       brake,
  output logic [9:0] duty,
  output logic       ramp_done,
  output logic       period_end
`ifdef DUTY_CLAMP_EN
  ,
  output logic       clamp_hit
`endif
);

  typedef enum logic [1:0] {HOLD, RAMP, BRAKE} state_t;

  localparam logic [10:0] STEP_C = 11'(STEP);

  if (STEP == 0 || STEP > 1023 || MAX_DUTY > 1023) begin : g_param_check
    $error("duty_ramp: STEP must be 1..1023 and MAX_DUTY at most 1023");
  end

  state_t      state_q, state_d;
  logic [9:0]  cnt_q;
  logic [9:0]  duty_q, duty_d;
  logic [9:0]  tgt_q, tgt_d;
  logic        ramp_done_q;
  logic [9:0]  tgt_in;
  logic        xfer;
  logic [10:0] diff;
  logic [10:0] up_sum;
  logic [10:0] dn_sum;

  assign tgt_rdy    = (state_q != BRAKE);
  assign period_end = (cnt_q == 10'd1023);
  assign duty       = duty_q;
  assign ramp_done  = ramp_done_q;
  // brake has priority over any handshake in the same cycle
  assign xfer       = tgt_vld & tgt_rdy & ~brake;

`ifdef DUTY_CLAMP_EN
  localparam logic [9:0] MAX_DUTY_C = 10'(MAX_DUTY);

  logic clamp_hit_q;
  logic over;

  assign over      = (tgt_duty > MAX_DUTY_C);
  assign tgt_in    = over ? MAX_DUTY_C : tgt_duty;
  assign clamp_hit = clamp_hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_hit_q <= 1'b0;
    end else begin
      clamp_hit_q <= xfer & over;
    end
  end
`else
  assign tgt_in = tgt_duty;
`endif

  // The 11-bit difference is always positive, so a step larger than diff can never be taken
  assign diff   = (tgt_q > duty_q) ? ({1'b0, tgt_q} - {1'b0, duty_q})
                                   : ({1'b0, duty_q} - {1'b0, tgt_q});
  assign up_sum = {1'b0, duty_q} + STEP_C;
  assign dn_sum = {1'b0, duty_q} - STEP_C;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    if (brake) begin
      state_d = BRAKE;
      duty_d  = '0;
      tgt_d   = '0;
    end else if (state_q == BRAKE) begin
      state_d = HOLD;
    end else begin
      if (state_q == RAMP && period_end) begin
        if (diff <= STEP_C) begin
          duty_d  = tgt_q;
          state_d = HOLD;
        end else if (tgt_q > duty_q) begin
          duty_d = up_sum[9:0];
        end else begin
          duty_d = dn_sum[9:0];
        end
      end
      // A boundary step above already used the old target; the new one applies from the next boundary
      if (xfer) begin
        tgt_d   = tgt_in;
        state_d = (tgt_in != duty_d) ? RAMP : HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      duty_q      <= '0;
      tgt_q       <= '0;
      state_q     <= HOLD;
      ramp_done_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_q + 10'd1;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      state_q     <= state_d;
      ramp_done_q <= (state_d == HOLD);
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Scenario bench for duty_ramp: expected boundary duties are queued when a target is sent
// and popped as each PWM period boundary is observed.
module tb_duty_ramp;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [9:0] tgt_duty = '0;
  logic       tgt_vld  = 1'b0;
  logic       brake    = 1'b0;
  logic       tgt_rdy;
  logic [9:0] duty;
  logic       ramp_done;
  logic       period_end;
`ifdef DUTY_CLAMP_EN
  logic       clamp_hit;
`endif

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  duty_ramp #(.STEP(8), .MAX_DUTY(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_duty   (tgt_duty),
    .tgt_vld    (tgt_vld),
    .tgt_rdy    (tgt_rdy),
    .brake      (brake),
    .duty       (duty),
    .ramp_done  (ramp_done),
    .period_end (period_end)
`ifdef DUTY_CLAMP_EN
    ,
    .clamp_hit  (clamp_hit)
`endif
  );

  // Slew model: queue the duty expected at each boundary from 'from' to 'to' with step 8
  task automatic push_ramp(input int from, input int to);
    int d;
    d = from;
    while (d != to) begin
      if (to > d) d = ((to - d) <= 8) ? to : d + 8;
      else        d = ((d - to) <= 8) ? to : d - 8;
      exp_q.push_back(10'(d));
    end
  endtask

  // Called at a negedge; returns at the negedge just after the next boundary edge
  task automatic wait_boundary(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (period_end) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
    end else begin
      checks++;
      errors++;
      $display("FAIL boundary_timeout: period_end never seen within 1100 cycles, required within 1024");
    end
  endtask

  task automatic send(input logic [9:0] t);
    tgt_duty = t;
    tgt_vld  = 1'b1;
    @(negedge clk);
    tgt_vld  = 1'b0;
    $display("xfer tgt=%0d duty=%0d", t, duty);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (duty !== 10'd0)     begin errors++; $display("FAIL reset_duty: got %0d, required 0", duty); end
    checks++; if (ramp_done !== 1'b1) begin errors++; $display("FAIL reset_ramp_done: got %b, required 1", ramp_done); end
    checks++; if (tgt_rdy !== 1'b1)   begin errors++; $display("FAIL reset_tgt_rdy: got %b, required 1", tgt_rdy); end
    checks++; if (period_end !== 1'b0) begin errors++; $display("FAIL reset_period_end: got %b, required 0", period_end); end
    rst_n = 1'b1;
    n = 0;
    while (!period_end && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 1023) begin errors++; $display("FAIL period_len: period_end after %0d cycles, required 1023", n); end
    else $display("period_end after %0d cycles", n);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ramp_up();
    bit ok;
    logic [9:0] e;
    exp_q.delete();
    send(10'd100);
    push_ramp(0, 100);
    checks++; if (ramp_done !== 1'b0) begin errors++; $display("FAIL up_ramp_done_start: got %b, required 0", ramp_done); end
    for (int i = 0; i < 13; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      $display("up boundary %0d duty=%0d expect=%0d", i + 1, duty, e);
      checks++; if (duty !== e) begin errors++; $display("FAIL up_duty[%0d]: got %0d, required %0d", i + 1, duty, e); end
      checks++;
      if (ramp_done !== (i == 12)) begin
        errors++; $display("FAIL up_ramp_done[%0d]: got %b, required %b", i + 1, ramp_done, (i == 12));
      end
      if (i == 0) begin
        repeat (300) @(negedge clk);
        checks++; if (duty !== e) begin errors++; $display("FAIL up_mid_period: got %0d, required %0d", duty, e); end
      end
    end
  endtask

  task automatic test_ramp_down();
    bit ok;
    logic [9:0] e;
    exp_q.delete();
    send(10'd0);
    push_ramp(100, 0);
    for (int i = 0; i < 13; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      $display("down boundary %0d duty=%0d expect=%0d", i + 1, duty, e);
      checks++; if (duty !== e) begin errors++; $display("FAIL down_duty[%0d]: got %0d, required %0d", i + 1, duty, e); end
    end
    checks++; if (ramp_done !== 1'b1) begin errors++; $display("FAIL down_ramp_done_end: got %b, required 1", ramp_done); end
  endtask

  task automatic test_retarget();
    bit ok;
    logic [9:0] e;
    exp_q.delete();
    send(10'd100);
    push_ramp(0, 40);
    for (int i = 0; i < 5; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      checks++; if (duty !== e) begin errors++; $display("FAIL retarget_pre[%0d]: got %0d, required %0d", i + 1, duty, e); end
    end
    checks++; if (tgt_rdy !== 1'b1) begin errors++; $display("FAIL retarget_rdy: got %b, required 1", tgt_rdy); end
    send(10'd20);
    exp_q.delete();
    push_ramp(40, 20);
    for (int i = 0; i < 3; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      $display("retarget boundary %0d duty=%0d expect=%0d", i + 1, duty, e);
      checks++; if (duty !== e) begin errors++; $display("FAIL retarget_duty[%0d]: got %0d, required %0d", i + 1, duty, e); end
    end
    checks++; if (ramp_done !== 1'b1) begin errors++; $display("FAIL retarget_done: got %b, required 1", ramp_done); end
  endtask

  task automatic test_boundary_xfer();
    bit ok;
    int n;
    logic [9:0] e;
    exp_q.delete();
    send(10'd16);
    push_ramp(20, 16);
    wait_boundary(ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (duty !== e) begin errors++; $display("FAIL bxfer_setup: got %0d, required %0d", duty, e); end
    end
    send(10'd100);
    exp_q.delete();
    exp_q.push_back(10'd24);
    n = 0;
    while (!period_end && n < 1100) begin
      @(negedge clk);
      n++;
    end
    tgt_duty = 10'd0;
    tgt_vld  = 1'b1;
    @(negedge clk);
    tgt_vld  = 1'b0;
    $display("xfer tgt=0 on boundary edge, duty=%0d", duty);
    e = exp_q.pop_front();
    checks++; if (duty !== e) begin errors++; $display("FAIL bxfer_old_target: got %0d, required %0d", duty, e); end
    push_ramp(24, 0);
    for (int i = 0; i < 3; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      $display("bxfer boundary %0d duty=%0d expect=%0d", i + 1, duty, e);
      checks++; if (duty !== e) begin errors++; $display("FAIL bxfer_duty[%0d]: got %0d, required %0d", i + 1, duty, e); end
    end
  endtask

  task automatic test_brake();
    bit ok;
    logic [9:0] e;
    exp_q.delete();
    send(10'd100);
    push_ramp(0, 48);
    for (int i = 0; i < 6; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      checks++; if (duty !== e) begin errors++; $display("FAIL brake_pre[%0d]: got %0d, required %0d", i + 1, duty, e); end
    end
    repeat (10) @(negedge clk);
    brake = 1'b1;
    @(negedge clk);
    $display("brake asserted duty=%0d", duty);
    checks++; if (duty !== 10'd0)     begin errors++; $display("FAIL brake_duty: got %0d, required 0", duty); end
    checks++; if (tgt_rdy !== 1'b0)   begin errors++; $display("FAIL brake_rdy: got %b, required 0", tgt_rdy); end
    checks++; if (ramp_done !== 1'b0) begin errors++; $display("FAIL brake_done: got %b, required 0", ramp_done); end
    tgt_duty = 10'd200;
    tgt_vld  = 1'b1;
    repeat (3) @(negedge clk);
    tgt_vld  = 1'b0;
    brake    = 1'b0;
    @(negedge clk);
    $display("brake released duty=%0d", duty);
    checks++; if (tgt_rdy !== 1'b1)   begin errors++; $display("FAIL release_rdy: got %b, required 1", tgt_rdy); end
    checks++; if (ramp_done !== 1'b1) begin errors++; $display("FAIL release_done: got %b, required 1", ramp_done); end
    exp_q.push_back(10'd0);
    wait_boundary(ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (duty !== e) begin errors++; $display("FAIL release_hold: got %0d, required %0d", duty, e); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    logic [9:0] e;
    exp_q.delete();
    send(10'd64);
    push_ramp(0, 64);
    for (int i = 0; i < 8; i++) begin
      wait_boundary(ok);
      if (!ok) break;
      e = exp_q.pop_front();
      checks++; if (duty !== e) begin errors++; $display("FAIL areset_pre[%0d]: got %0d, required %0d", i + 1, duty, e); end
    end
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset pulsed duty=%0d", duty);
    checks++; if (duty !== 10'd0)     begin errors++; $display("FAIL areset_duty: got %0d, required 0", duty); end
    checks++; if (ramp_done !== 1'b1) begin errors++; $display("FAIL areset_done: got %b, required 1", ramp_done); end
    checks++; if (tgt_rdy !== 1'b1)   begin errors++; $display("FAIL areset_rdy: got %b, required 1", tgt_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!period_end && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 1023) begin errors++; $display("FAIL areset_cnt: period_end after %0d cycles, required 1023", n); end
  endtask

`ifdef DUTY_CLAMP_EN
  task automatic test_clamp();
    repeat (5) @(negedge clk);
    send(10'd1023);
    checks++; if (clamp_hit !== 1'b1) begin errors++; $display("FAIL clamp_pulse: got %b, required 1", clamp_hit); end
    @(negedge clk);
    checks++; if (clamp_hit !== 1'b0) begin errors++; $display("FAIL clamp_width: got %b, required 0", clamp_hit); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_retarget();
    test_boundary_xfer();
    test_brake();
    test_async_reset();
`ifdef DUTY_CLAMP_EN
    test_clamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
